// File: rtl/commit_ctrl.sv
// commit_ctrl: in-order retire of the ROB head into the regfile, the LSB
// (store handshake) or a mispredict redirect followed by a multi-cycle clear.
// Optional feature macro: COMMIT_PERF_CNT_EN adds the 64-bit retired_cnt port.
module commit_ctrl #(
  parameter int TAG_W        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic             rob_head_valid,
  input  logic [TAG_W-1:0] rob_head_tag,
  input  logic [4:0]       rob_head_dest,
  input  logic [31:0]      rob_head_data,
  input  logic             rob_head_is_store,
  input  logic             rob_head_mispredict,
  input  logic [31:0]      rob_head_target,
  output logic             rob_head_pop,
  output logic             rf_wr_valid,
  output logic [4:0]       rf_wr_dest,
  output logic [TAG_W-1:0] rf_wr_tag,
  output logic [31:0]      rf_wr_data,
  output logic             lsb_commit_valid,
  input  logic             lsb_commit_ack,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             clear
`ifdef COMMIT_PERF_CNT_EN
  ,
  output logic [63:0]      retired_cnt
`endif
);

  typedef enum logic [1:0] {RUN, STORE, FLUSH} state_t;

  state_t     state, state_nxt;
  logic [3:0] flush_cnt, flush_cnt_nxt;
  logic       pop_run;

  // Retire decision and next state; rdy=0 or reset freezes everything.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    rob_head_pop  = 1'b0;
    case (state)
      RUN: begin
        if (rob_head_valid) begin
          if (rob_head_mispredict) begin
            rob_head_pop  = 1'b1;
            state_nxt     = FLUSH;
            flush_cnt_nxt = 4'(FLUSH_CYCLES);
          end else if (rob_head_is_store) begin
            state_nxt = STORE;
          end else begin
            rob_head_pop = 1'b1;
          end
        end
      end
      STORE: begin
        if (lsb_commit_ack) begin
          rob_head_pop = 1'b1;
          state_nxt    = RUN;
        end
      end
      FLUSH: begin
        flush_cnt_nxt = flush_cnt - 4'd1;
        if (flush_cnt <= 4'd1) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
    if (!rdy || !rst_n) begin
      rob_head_pop  = 1'b0;
      state_nxt     = state;
      flush_cnt_nxt = flush_cnt;
    end
  end

  // Pops taken from RUN carry the regfile write and any redirect.
  assign pop_run = rob_head_pop && (state == RUN);

  // State, counter and registered outputs; everything holds while rdy=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= RUN;
      flush_cnt        <= 4'd0;
      rf_wr_valid      <= 1'b0;
      rf_wr_dest       <= 5'd0;
      rf_wr_tag        <= '0;
      rf_wr_data       <= 32'd0;
      lsb_commit_valid <= 1'b0;
      redirect_valid   <= 1'b0;
      redirect_pc      <= 32'd0;
      clear            <= 1'b0;
    end else if (rdy) begin
      state            <= state_nxt;
      flush_cnt        <= flush_cnt_nxt;
      rf_wr_valid      <= pop_run && (rob_head_dest != 5'd0);
      if (pop_run) begin
        rf_wr_dest <= rob_head_dest;
        rf_wr_tag  <= rob_head_tag;
        rf_wr_data <= rob_head_data;
      end
      redirect_valid   <= pop_run && rob_head_mispredict;
      if (pop_run && rob_head_mispredict) redirect_pc <= rob_head_target;
      lsb_commit_valid <= (state_nxt == STORE);
      clear            <= (state_nxt == FLUSH);
    end
  end

`ifdef COMMIT_PERF_CNT_EN
  // Retirement counter, wraps naturally at 2^64.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            retired_cnt <= 64'd0;
    else if (rob_head_pop) retired_cnt <= retired_cnt + 64'd1;
  end
`endif

endmodule

// File: tb/tb_commit_ctrl.sv
// tb_commit_ctrl: directed test-plan scenarios followed by randomized traffic,
// all checked against a transaction-level reference model.
module tb_commit_ctrl;
  localparam int TAG_W = 4;
  localparam int FC    = 2;

  logic             clk = 1'b0;
  logic             rst_n, rdy;
  logic             rob_head_valid, rob_head_is_store, rob_head_mispredict;
  logic [TAG_W-1:0] rob_head_tag;
  logic [4:0]       rob_head_dest;
  logic [31:0]      rob_head_data, rob_head_target;
  logic             rob_head_pop, rf_wr_valid, lsb_commit_valid, lsb_commit_ack;
  logic [4:0]       rf_wr_dest;
  logic [TAG_W-1:0] rf_wr_tag;
  logic [31:0]      rf_wr_data, redirect_pc;
  logic             redirect_valid, clear;
`ifdef COMMIT_PERF_CNT_EN
  logic [63:0]      retired_cnt;
`endif

  commit_ctrl #(.TAG_W(TAG_W), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .rob_head_valid(rob_head_valid), .rob_head_tag(rob_head_tag),
    .rob_head_dest(rob_head_dest), .rob_head_data(rob_head_data),
    .rob_head_is_store(rob_head_is_store), .rob_head_mispredict(rob_head_mispredict),
    .rob_head_target(rob_head_target), .rob_head_pop(rob_head_pop),
    .rf_wr_valid(rf_wr_valid), .rf_wr_dest(rf_wr_dest), .rf_wr_tag(rf_wr_tag),
    .rf_wr_data(rf_wr_data), .lsb_commit_valid(lsb_commit_valid),
    .lsb_commit_ack(lsb_commit_ack), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .clear(clear)
`ifdef COMMIT_PERF_CNT_EN
    , .retired_cnt(retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the head is either free to retire, waiting on a store
  // ack, or blocked for a known number of remaining clear cycles.
  bit               busy_store;
  int               clear_left;
  bit               e_wr_v, e_lsb, e_redir, e_clear;
  logic [4:0]       e_dest;
  logic [TAG_W-1:0] e_tag;
  logic [31:0]      e_data, e_pc;
  longint unsigned  n_retired;

  task automatic model_reset();
    busy_store = 0; clear_left = 0;
    e_wr_v = 0; e_lsb = 0; e_redir = 0; e_clear = 0;
    e_dest = 0; e_tag = 0; e_data = 0; e_pc = 0;
    n_retired = 0;
  endtask

  task automatic chk_regs();
    chk("rf_wr_valid", rf_wr_valid, e_wr_v);
    if (e_wr_v) begin
      chk("rf_wr_dest", rf_wr_dest, e_dest);
      chk("rf_wr_tag", rf_wr_tag, e_tag);
      chk("rf_wr_data", rf_wr_data, e_data);
    end
    chk("lsb_commit_valid", lsb_commit_valid, e_lsb);
    chk("redirect_valid", redirect_valid, e_redir);
    if (e_redir) chk("redirect_pc", redirect_pc, e_pc);
    chk("clear", clear, e_clear);
`ifdef COMMIT_PERF_CNT_EN
    chk("retired_cnt", retired_cnt, n_retired);
`endif
  endtask

  // One clock: drive at negedge, check pop, advance model, check registers.
  task automatic step(input bit v, input logic [TAG_W-1:0] tg, input logic [4:0] d,
                      input logic [31:0] dat, input bit st, input bit mp,
                      input logic [31:0] tgt, input bit ack, input bit r);
    bit exp_pop, plain_retire;
    @(negedge clk);
    rob_head_valid = v; rob_head_tag = tg; rob_head_dest = d; rob_head_data = dat;
    rob_head_is_store = st; rob_head_mispredict = mp; rob_head_target = tgt;
    lsb_commit_ack = ack; rdy = r;
    #1;
    plain_retire = (clear_left == 0) && !busy_store && v && (mp || !st);
    exp_pop = r && (plain_retire || (busy_store && ack));
    chk("rob_head_pop", rob_head_pop, exp_pop);
    if (r) begin
      if (exp_pop) n_retired++;
      e_wr_v  = plain_retire && (d != 0);
      e_redir = plain_retire && mp;
      if (plain_retire) begin e_dest = d; e_tag = tg; e_data = dat; end
      if (plain_retire && mp) e_pc = tgt;
      if (clear_left > 0) clear_left--;
      else if (busy_store) busy_store = !ack;
      else if (plain_retire && mp) clear_left = FC;
      else if (v && st) busy_store = 1;
      e_lsb   = busy_store;
      e_clear = clear_left > 0;
    end
    @(posedge clk); #1;
    chk_regs();
  endtask

  task automatic plain(input logic [4:0] d, input logic [31:0] dat, input logic [TAG_W-1:0] tg);
    step(1, tg, d, dat, 0, 0, 0, 0, 1);
  endtask

  initial begin
    rst_n = 0; rdy = 0; rob_head_valid = 0; rob_head_tag = 0; rob_head_dest = 0;
    rob_head_data = 0; rob_head_is_store = 0; rob_head_mispredict = 0;
    rob_head_target = 0; lsb_commit_ack = 0;
    model_reset();
    #23;
    chk("reset_pop", rob_head_pop, 0);
    chk_regs();
    @(negedge clk); rst_n = 1;

    // Mispredict, then reset in the middle of the flush.
    step(1, 1, 3, 32'h55, 0, 1, 32'h400, 0, 1);
    step(1, 2, 4, 32'h66, 0, 0, 0, 0, 1);
    @(negedge clk);
    rst_n = 0; rob_head_valid = 1; rdy = 1; #1;
    model_reset();
    chk("rst_mid_flush_pop", rob_head_pop, 0);
    chk_regs();
    #2 rst_n = 1;
    plain(5, 32'h1234, 3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Back-to-back plain ops, middle one to x0.
    plain(1, 32'hA1, 4);
    plain(0, 32'hA2, 5);
    plain(2, 32'hA3, 6);

    // Store with the ack delayed 3 cycles; the ack outside STORE is ignored first.
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(1, 7, 9, 32'hBEEF, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 7, 9, 32'hBEEF, 1, 0, 0, 0, 1);
    step(1, 7, 9, 32'hBEEF, 1, 0, 0, 1, 1);

    // Mispredict jump: head stays valid throughout the flush.
    step(1, 8, 1, 32'h104, 0, 1, 32'h200, 0, 1);
    step(1, 9, 6, 32'h77, 0, 0, 0, 0, 1);
    step(1, 9, 6, 32'h77, 0, 0, 0, 0, 1);
    step(1, 9, 6, 32'h77, 0, 0, 0, 0, 1);

    // rdy dropped for 2 cycles during FLUSH and during STORE.
    step(1, 10, 2, 32'h88, 0, 1, 32'h300, 0, 1);
    step(1, 11, 3, 32'h99, 0, 0, 0, 0, 0);
    step(1, 11, 3, 32'h99, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 11, 3, 32'h99, 0, 0, 0, 0, 1);
    step(1, 12, 0, 32'h0, 1, 0, 0, 0, 1);
    step(1, 12, 0, 32'h0, 1, 0, 0, 1, 0);
    step(1, 12, 0, 32'h0, 1, 0, 0, 1, 0);
    step(1, 12, 0, 32'h0, 1, 0, 0, 1, 1);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      int k;
      bit st, mp;
      k  = int'($urandom_range(0, 9));
      st = (k == 0) || (k == 1);
      mp = (k == 2) || (k == 1 && $urandom_range(0, 1) == 1);
      step($urandom_range(0, 4) != 0, TAG_W'($urandom), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom),
           $urandom, st, mp, $urandom, $urandom_range(0, 2) == 0, $urandom_range(0, 6) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
